// File: rtl/writeback_stage_pkg.sv
// Shared encodings for the writeback stage: result-source select and load funct3 codes.
package writeback_stage_pkg;
    localparam int XLEN_DEF = 32;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } result_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/writeback_stage_if.sv
// MEM->WB instruction bus plus the register-file write port toward decode.
interface writeback_stage_if
    import writeback_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    logic            mem_valid;
    logic [XLEN-1:0] mem_alu_result;
    logic [XLEN-1:0] mem_read_data;
    logic [XLEN-1:0] mem_pc_plus4;
    logic [XLEN-1:0] mem_imm;
    logic [4:0]      mem_rd;
    logic            mem_reg_write;
    logic [1:0]      mem_result_src;
    logic [2:0]      mem_funct3;

    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_write_data;
    logic            wb_reg_write;
    logic            wb_valid;
    logic            wb_load_fault;

    modport master (
        output mem_valid, mem_alu_result, mem_read_data, mem_pc_plus4, mem_imm,
               mem_rd, mem_reg_write, mem_result_src, mem_funct3,
        input  wb_rd, wb_write_data, wb_reg_write, wb_valid, wb_load_fault
    );

    modport slave (
        input  mem_valid, mem_alu_result, mem_read_data, mem_pc_plus4, mem_imm,
               mem_rd, mem_reg_write, mem_result_src, mem_funct3,
        output wb_rd, wb_write_data, wb_reg_write, wb_valid, wb_load_fault
    );
endinterface

// File: rtl/writeback_stage_load_formatter.sv
// Extracts and extends a byte/halfword/word from an aligned load word; flags reserved funct3.
module load_formatter
    import writeback_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] read_data,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            fault
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halfword lane uses only off[1]; misalignment is rejected before this stage.
    assign byte_sel = read_data[{off, 3'b000} +: 8];
    assign half_sel = read_data[{off[1], 4'b0000} +: 16];

    always_comb begin
        data  = read_data;
        fault = 1'b0;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LW:   data = read_data;
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
            default: fault = 1'b1;
        endcase
    end
endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: MEM/WB register, result select, x0 suppression and retire counter.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    writeback_stage_if.slave  bus,
    input  logic              stall,
    input  logic              flush,
    output logic [CNT_W-1:0]  retire_count
);
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] read_data;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic            reg_write;
        result_src_e     result_src;
        logic [2:0]      funct3;
    } mw_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    mw_t             mw_q, mw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] ld_data;
    logic            ld_fault;

    always_comb begin
        mw_d = mw_q;
        if (flush) begin
            mw_d = '0;
        end else if (!stall) begin
            mw_d.valid      = bus.mem_valid;
            mw_d.alu_result = bus.mem_alu_result;
            mw_d.read_data  = bus.mem_read_data;
            mw_d.pc_plus4   = bus.mem_pc_plus4;
            mw_d.imm        = bus.mem_imm;
            mw_d.rd         = bus.mem_rd;
            mw_d.reg_write  = bus.mem_reg_write;
            mw_d.result_src = result_src_e'(bus.mem_result_src);
            mw_d.funct3     = bus.mem_funct3;
        end
    end

    // An instruction retires on the edge it leaves WB, so a stalled one counts once.
    always_comb begin
        cnt_d = cnt_q;
        if (mw_q.valid && (!stall || flush))
            cnt_d = cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mw_q  <= '0;
            cnt_q <= '0;
        end else begin
            mw_q  <= mw_d;
            cnt_q <= cnt_d;
        end
    end

    load_formatter #(.XLEN(XLEN)) u_fmt (
        .read_data (mw_q.read_data),
        .off       (mw_q.alu_result[1:0]),
        .funct3    (mw_q.funct3),
        .data      (ld_data),
        .fault     (ld_fault)
    );

    always_comb begin
        bus.wb_write_data = mw_q.alu_result;
        case (mw_q.result_src)
            RES_ALU: bus.wb_write_data = mw_q.alu_result;
            RES_MEM: bus.wb_write_data = ld_data;
            RES_PC4: bus.wb_write_data = mw_q.pc_plus4;
            RES_IMM: bus.wb_write_data = mw_q.imm;
            default: bus.wb_write_data = mw_q.alu_result;
        endcase
    end

    assign bus.wb_rd         = mw_q.rd;
    assign bus.wb_valid      = mw_q.valid;
    assign bus.wb_reg_write  = mw_q.valid & mw_q.reg_write & (mw_q.rd != 5'd0);
    assign bus.wb_load_fault = mw_q.valid & (mw_q.result_src == RES_MEM) & ld_fault;
    assign retire_count      = cnt_q;
endmodule
